qep_decoder: RTL

QEP_DECODER -- requirements
Module: qep_decoder

---
 rtl/qep_pkg.sv | 9 +
 rtl/qep_glitch_filter.sv | 32 +++
 rtl/qep_decoder.sv | 100 ++++++++++
 3 files changed

// File: rtl/qep_pkg.sv
// qep_pkg: shared state type, default widths and quadrature step table for the QEP decoder.
package qep_pkg;
   typedef enum logic {INIT, RUN} qep_state_t;
   localparam int POS_W_DEF = 32;
   localparam int ERR_W_DEF = 8;
   // Indexed by {prev_ab, cur_ab}; a set bit marks a forward step (00->01->11->10->00).
   // A reverse step is the same table indexed by {cur_ab, prev_ab}.
   localparam logic [15:0] FWD_LUT = 16'h4182;
endpackage

// File: rtl/qep_glitch_filter.sv
// qep_glitch_filter: accepts a new input level only after FILT_CYC consecutive differing samples.
module qep_glitch_filter
   import qep_pkg::*;
#(
   parameter int FILT_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic init,
   input  logic clr,
   input  logic raw,
   output logic filt
);
   logic [3:0] cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         filt <= 1'b0;
      end else if (init || !en) begin
         filt <= raw;
         cnt  <= '0;
      end else if (clr || raw == filt) begin
         cnt <= '0;
      end else if (cnt == 4'(FILT_CYC - 1)) begin
         filt <= raw;
         cnt  <= '0;
      end else begin
         cnt <= cnt + 4'd1;
      end
   end
endmodule

// File: rtl/qep_decoder.sv
// qep_decoder: filtered quadrature decoder with position counter, index capture and
// illegal-transition tracking.
module qep_decoder
   import qep_pkg::*;
#(
   parameter int POS_W    = POS_W_DEF,
   parameter int FILT_CYC = 4,
   parameter int ERR_W    = ERR_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_sync,
   input  logic             b_sync,
   input  logic             idx_sync,
   input  logic             filt_en,
   input  logic             idx_clr_en,
   input  logic             load,
   input  logic [POS_W-1:0] load_val,
   input  logic             err_clr,
   output logic [POS_W-1:0] pos,
   output logic             dir,
   output logic             step,
   output logic [POS_W-1:0] idx_pos,
   output logic             idx_evt,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);
   qep_state_t       state_q, state_n;
   logic             a_f, b_f, idx_f, filt_en_q, en_chg, init;
   logic [1:0]       prev_ab, ab_f;
   logic             prev_idx, run, fwd, rev, ill, idx_rise;
   logic [POS_W-1:0] pos_n;
   logic [ERR_W-1:0] err_cnt_n;
   logic             err_n, dir_n;

   assign init   = state_q == INIT;
   assign en_chg = filt_en ^ filt_en_q;
   assign ab_f   = {a_f, b_f};

   qep_glitch_filter #(.FILT_CYC(FILT_CYC)) u_filt_a (
      .clk(clk), .rst(rst), .en(filt_en), .init(init), .clr(en_chg), .raw(a_sync), .filt(a_f)
   );
   qep_glitch_filter #(.FILT_CYC(FILT_CYC)) u_filt_b (
      .clk(clk), .rst(rst), .en(filt_en), .init(init), .clr(en_chg), .raw(b_sync), .filt(b_f)
   );
   qep_glitch_filter #(.FILT_CYC(FILT_CYC)) u_filt_idx (
      .clk(clk), .rst(rst), .en(filt_en), .init(init), .clr(en_chg), .raw(idx_sync), .filt(idx_f)
   );

   always_comb begin
      state_n   = RUN;
      run       = state_q == RUN;
      fwd       = run && FWD_LUT[{prev_ab, ab_f}];
      rev       = run && FWD_LUT[{ab_f, prev_ab}];
      ill       = run && (&(prev_ab ^ ab_f));
      idx_rise  = run && idx_f && !prev_idx;
      // Load beats an index clear, which beats the decoded step.
      pos_n     = load ? load_val
                : (idx_rise && idx_clr_en) ? '0
                : fwd ? pos + POS_W'(1)
                : rev ? pos - POS_W'(1)
                : pos;
      dir_n     = fwd ? 1'b1 : rev ? 1'b0 : dir;
      err_n     = ill || (err && !err_clr);
      err_cnt_n = err_clr ? (ill ? ERR_W'(1) : '0)
                : (ill && !(&err_cnt)) ? err_cnt + ERR_W'(1)
                : err_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= INIT;
      else     state_q <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_ab   <= '0;
         prev_idx  <= 1'b0;
         filt_en_q <= 1'b0;
         pos       <= '0;
         dir       <= 1'b0;
         step      <= 1'b0;
         idx_pos   <= '0;
         idx_evt   <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
      end else begin
         prev_ab   <= init ? {a_sync, b_sync} : ab_f;
         prev_idx  <= init ? idx_sync : idx_f;
         filt_en_q <= filt_en;
         pos       <= pos_n;
         dir       <= dir_n;
         step      <= fwd || rev;
         idx_evt   <= idx_rise;
         if (idx_rise) idx_pos <= pos;
         err       <= err_n;
         err_cnt   <= err_cnt_n;
      end
   end
endmodule
